dmem_arbiter: RTL and testbench

- Shares the single-port data memory between two requesters: port 0 is the CPU load/store path, port 1 is the loader/debug path that initialises or inspects memory.
- Arbitrates with valid/ready request handshakes and returns one-cycle response pulses.
- Drives the memory's MemRead, MemWrite, a and wd inputs from registered state and captures rd into a response register.
- Sits between the control unit/ALU address path and the data memory instance.

---
 rtl/dmem_arbiter.sv | 173 +++++++++++++++++
 tb/tb_dmem_arbiter.sv | 429 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_arbiter.sv
// Shares the single-port data memory between the CPU path (port 0) and the
// loader/debug path (port 1). Each access is accepted, performed, then answered.
module dmem_arbiter #(
    parameter int DM_ADDRESS = 9,
    parameter int DATA_W     = 32,
    parameter bit FIXED_PRIO = 1'b0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req0_valid,
    output logic                  req0_ready,
    input  logic                  req0_we,
    input  logic [DM_ADDRESS-1:0] req0_addr,
    input  logic [DATA_W-1:0]     req0_wdata,
    output logic                  resp0_valid,
    output logic [DATA_W-1:0]     resp0_rdata,
    input  logic                  req1_valid,
    output logic                  req1_ready,
    input  logic                  req1_we,
    input  logic [DM_ADDRESS-1:0] req1_addr,
    input  logic [DATA_W-1:0]     req1_wdata,
    output logic                  resp1_valid,
    output logic [DATA_W-1:0]     resp1_rdata,
    output logic                  MemRead,
    output logic                  MemWrite,
    output logic [DM_ADDRESS-1:0] a,
    output logic [DATA_W-1:0]     wd,
    input  logic [DATA_W-1:0]     rd
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    state_t                state_q, state_d;
    logic                  last_grant_q, last_grant_d;
    logic                  owner_q, owner_d;
    logic                  we_q, we_d;
    logic [DM_ADDRESS-1:0] addr_q, addr_d;
    logic [DATA_W-1:0]     wdata_q, wdata_d;
    logic [DATA_W-1:0]     rdata_q, rdata_d;

    logic                  mem_read_q, mem_read_d;
    logic                  mem_write_q, mem_write_d;
    logic [DM_ADDRESS-1:0] a_q, a_d;
    logic [DATA_W-1:0]     wd_q, wd_d;
    logic                  resp0_valid_q, resp0_valid_d;
    logic                  resp1_valid_q, resp1_valid_d;
    logic [DATA_W-1:0]     resp0_rdata_q, resp0_rdata_d;
    logic [DATA_W-1:0]     resp1_rdata_q, resp1_rdata_d;

    logic                  grant_sel;
    logic                  accept;
    logic                  sel_we;
    logic [DM_ADDRESS-1:0] sel_addr;
    logic [DATA_W-1:0]     sel_wdata;

    // Arbitration: under contention round-robin favours the port not granted last.
    always_comb begin
        if (req0_valid && req1_valid) begin
            grant_sel = FIXED_PRIO ? 1'b0 : ~last_grant_q;
        end else begin
            grant_sel = req1_valid;
        end
        accept     = !reset && (state_q == IDLE) && (req0_valid || req1_valid);
        req0_ready = accept && !grant_sel;
        req1_ready = accept && grant_sel;
        sel_we     = grant_sel ? req1_we    : req0_we;
        sel_addr   = grant_sel ? req1_addr  : req0_addr;
        sel_wdata  = grant_sel ? req1_wdata : req0_wdata;
    end

    // Memory and response outputs are computed one state ahead so they come straight from flops.
    always_comb begin
        state_d       = state_q;
        last_grant_d  = last_grant_q;
        owner_d       = owner_q;
        we_d          = we_q;
        addr_d        = addr_q;
        wdata_d       = wdata_q;
        rdata_d       = rdata_q;
        mem_read_d    = 1'b0;
        mem_write_d   = 1'b0;
        a_d           = '0;
        wd_d          = '0;
        resp0_valid_d = 1'b0;
        resp1_valid_d = 1'b0;
        resp0_rdata_d = '0;
        resp1_rdata_d = '0;

        case (state_q)
            IDLE: begin
                if (accept) begin
                    owner_d      = grant_sel;
                    last_grant_d = grant_sel;
                    we_d         = sel_we;
                    addr_d       = sel_addr;
                    wdata_d      = sel_wdata;
                    mem_write_d  = sel_we;
                    mem_read_d   = !sel_we;
                    a_d          = sel_addr;
                    wd_d         = sel_wdata;
                    state_d      = ACCESS;
                end
            end
            ACCESS: begin
                rdata_d = we_q ? '0 : rd;
                if (owner_q) begin
                    resp1_valid_d = 1'b1;
                    resp1_rdata_d = rdata_d;
                end else begin
                    resp0_valid_d = 1'b1;
                    resp0_rdata_d = rdata_d;
                end
                state_d = RESP;
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= IDLE;
            last_grant_q  <= 1'b1;
            owner_q       <= 1'b0;
            we_q          <= 1'b0;
            addr_q        <= '0;
            wdata_q       <= '0;
            rdata_q       <= '0;
            mem_read_q    <= 1'b0;
            mem_write_q   <= 1'b0;
            a_q           <= '0;
            wd_q          <= '0;
            resp0_valid_q <= 1'b0;
            resp1_valid_q <= 1'b0;
            resp0_rdata_q <= '0;
            resp1_rdata_q <= '0;
        end else begin
            state_q       <= state_d;
            last_grant_q  <= last_grant_d;
            owner_q       <= owner_d;
            we_q          <= we_d;
            addr_q        <= addr_d;
            wdata_q       <= wdata_d;
            rdata_q       <= rdata_d;
            mem_read_q    <= mem_read_d;
            mem_write_q   <= mem_write_d;
            a_q           <= a_d;
            wd_q          <= wd_d;
            resp0_valid_q <= resp0_valid_d;
            resp1_valid_q <= resp1_valid_d;
            resp0_rdata_q <= resp0_rdata_d;
            resp1_rdata_q <= resp1_rdata_d;
        end
    end

    assign MemRead     = mem_read_q;
    assign MemWrite    = mem_write_q;
    assign a           = a_q;
    assign wd          = wd_q;
    assign resp0_valid = resp0_valid_q;
    assign resp1_valid = resp1_valid_q;
    assign resp0_rdata = resp0_rdata_q;
    assign resp1_rdata = resp1_rdata_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: directed scenarios plus random traffic, checked every
// cycle against a transaction-level model of grants, memory accesses and responses.
module tb_dmem_arbiter;
    localparam int AW = 9;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          req0_valid = 1'b0, req0_we = 1'b0;
    logic [AW-1:0] req0_addr = '0;
    logic [DW-1:0] req0_wdata = '0;
    logic          req1_valid = 1'b0, req1_we = 1'b0;
    logic [AW-1:0] req1_addr = '0;
    logic [DW-1:0] req1_wdata = '0;

    logic          req0_ready, req1_ready, resp0_valid, resp1_valid;
    logic [DW-1:0] resp0_rdata, resp1_rdata;
    logic          mem_read, mem_write;
    logic [AW-1:0] a;
    logic [DW-1:0] wd, rd;

    logic          fp_req0_ready, fp_req1_ready, fp_resp0_valid, fp_resp1_valid;
    logic [DW-1:0] fp_resp0_rdata, fp_resp1_rdata;
    logic          fp_mem_read, fp_mem_write;
    logic [AW-1:0] fp_a;
    logic [DW-1:0] fp_wd, fp_rd;

    logic [DW-1:0] mem0 [512] = '{default: '0};
    logic [DW-1:0] memf [512] = '{default: '0};

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    assign rd    = mem0[a];
    assign fp_rd = memf[fp_a];
    always @(posedge clk) if (mem_write) mem0[a] <= wd;
    always @(posedge clk) if (fp_mem_write) memf[fp_a] <= fp_wd;

    dmem_arbiter #(.DM_ADDRESS(AW), .DATA_W(DW), .FIXED_PRIO(1'b0)) dut (
        .clk(clk), .reset(reset),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_we(req0_we),
        .req0_addr(req0_addr), .req0_wdata(req0_wdata),
        .resp0_valid(resp0_valid), .resp0_rdata(resp0_rdata),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_we(req1_we),
        .req1_addr(req1_addr), .req1_wdata(req1_wdata),
        .resp1_valid(resp1_valid), .resp1_rdata(resp1_rdata),
        .MemRead(mem_read), .MemWrite(mem_write), .a(a), .wd(wd), .rd(rd)
    );

    dmem_arbiter #(.DM_ADDRESS(AW), .DATA_W(DW), .FIXED_PRIO(1'b1)) dut_fp (
        .clk(clk), .reset(reset),
        .req0_valid(req0_valid), .req0_ready(fp_req0_ready), .req0_we(req0_we),
        .req0_addr(req0_addr), .req0_wdata(req0_wdata),
        .resp0_valid(fp_resp0_valid), .resp0_rdata(fp_resp0_rdata),
        .req1_valid(req1_valid), .req1_ready(fp_req1_ready), .req1_we(req1_we),
        .req1_addr(req1_addr), .req1_wdata(req1_wdata),
        .resp1_valid(fp_resp1_valid), .resp1_rdata(fp_resp1_rdata),
        .MemRead(fp_mem_read), .MemWrite(fp_mem_write), .a(fp_a), .wd(fp_wd), .rd(fp_rd)
    );

    // Transaction-level reference: one request in flight, accessed one cycle after
    // acceptance and answered the cycle after that.
    logic [DW-1:0] ref_mem [512] = '{default: '0};
    logic          m_last = 1'b1;
    logic          acc_pend = 1'b0, acc_we = 1'b0, acc_port = 1'b0;
    logic [AW-1:0] acc_addr = '0;
    logic [DW-1:0] acc_wdata = '0;
    logic          resp_pend = 1'b0, resp_port = 1'b0;
    logic [DW-1:0] resp_data = '0;

    always @(negedge clk) begin
        logic          idle, g, e_r0, e_r1;
        logic [AW+DW+1:0] e_mem;
        logic [2*DW+1:0]  e_resp;
        if (reset) begin
            checks++;
            if ({req0_ready, req1_ready, mem_read, mem_write, a, wd,
                 resp0_valid, resp0_rdata, resp1_valid, resp1_rdata} !== '0) begin
                failures++;
                $display("FAIL reset_outputs: rdy=%b%b rd=%b wr=%b a=%h wd=%h r0=%b/%h r1=%b/%h required all 0",
                         req0_ready, req1_ready, mem_read, mem_write, a, wd,
                         resp0_valid, resp0_rdata, resp1_valid, resp1_rdata);
            end
            acc_pend = 1'b0;
            resp_pend = 1'b0;
            m_last = 1'b1;
        end else begin
            idle = !acc_pend && !resp_pend;
            g    = (req0_valid && req1_valid) ? !m_last : req1_valid;
            e_r0 = idle && (req0_valid || req1_valid) && !g;
            e_r1 = idle && (req0_valid || req1_valid) && g;
            checks++;
            if ({req0_ready, req1_ready} !== {e_r0, e_r1}) begin
                failures++;
                $display("FAIL ready: got r0=%b r1=%b required r0=%b r1=%b",
                         req0_ready, req1_ready, e_r0, e_r1);
            end
            e_mem = acc_pend ? {!acc_we, acc_we, acc_addr, acc_wdata} : '0;
            checks++;
            if ({mem_read, mem_write, a, wd} !== e_mem) begin
                failures++;
                $display("FAIL mem_if: got rd=%b wr=%b a=%h wd=%h required {rd,wr,a,wd}=%h",
                         mem_read, mem_write, a, wd, e_mem);
            end
            e_resp = '0;
            if (resp_pend) begin
                if (resp_port) e_resp = {1'b0, {DW{1'b0}}, 1'b1, resp_data};
                else           e_resp = {1'b1, resp_data, 1'b0, {DW{1'b0}}};
            end
            checks++;
            if ({resp0_valid, resp0_rdata, resp1_valid, resp1_rdata} !== e_resp) begin
                failures++;
                $display("FAIL resp: got r0=%b/%h r1=%b/%h required %h",
                         resp0_valid, resp0_rdata, resp1_valid, resp1_rdata, e_resp);
            end
            resp_pend = 1'b0;
            if (acc_pend) begin
                resp_data = acc_we ? '0 : ref_mem[acc_addr];
                if (acc_we) ref_mem[acc_addr] = acc_wdata;
                resp_port = acc_port;
                resp_pend = 1'b1;
                acc_pend  = 1'b0;
            end
            if (e_r0 || e_r1) begin
                acc_pend  = 1'b1;
                acc_port  = g;
                acc_we    = g ? req1_we : req0_we;
                acc_addr  = g ? req1_addr : req0_addr;
                acc_wdata = g ? req1_wdata : req0_wdata;
                m_last    = g;
            end
        end
    end

    // Raises a single request and returns 1ns into the cycle after it was accepted.
    task automatic issue(input logic p, input logic we, input logic [AW-1:0] ad, input logic [DW-1:0] wdat);
        int n;
        @(posedge clk); #1;
        if (p) begin req1_valid = 1'b1; req1_we = we; req1_addr = ad; req1_wdata = wdat; end
        else   begin req0_valid = 1'b1; req0_we = we; req0_addr = ad; req0_wdata = wdat; end
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(p ? req1_ready : req0_ready) && n < 10);
        checks++;
        if (!(p ? req1_ready : req0_ready)) begin
            failures++;
            $display("FAIL issue_timeout: port %0d got no ready in %0d cycles, required ready", p, n);
        end
        @(posedge clk); #1;
        if (p) req1_valid = 1'b0; else req0_valid = 1'b0;
    endtask

    task automatic pulse_reset();
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk); #1 reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if ({req0_ready, req1_ready, mem_read, mem_write, a, wd, resp0_valid, resp1_valid} !== '0) begin
            failures++;
            $display("FAIL test_reset: outputs nonzero (rd=%b wr=%b a=%h) required 0", mem_read, mem_write, a);
        end
        @(posedge clk); #1 reset = 1'b0;
        @(negedge clk);
        checks++;
        if ({mem_read, mem_write, resp0_valid, resp1_valid, req0_ready, req1_ready} !== '0) begin
            failures++;
            $display("FAIL idle_after_reset: rd=%b wr=%b resp=%b%b required 0", mem_read, mem_write, resp0_valid, resp1_valid);
        end
        $display("test_reset done");
    endtask

    task automatic test_write_read();
        issue(1'b0, 1'b1, 9'h005, 32'hDEADBEEF);
        @(negedge clk);
        checks++;
        if (mem_write !== 1'b1 || a !== 9'h005) begin
            failures++;
            $display("FAIL wr_access: got wr=%b a=%h required wr=1 a=005", mem_write, a);
        end
        @(negedge clk);
        checks++;
        if (resp0_valid !== 1'b1 || resp1_valid !== 1'b0) begin
            failures++;
            $display("FAIL wr_resp: got r0=%b r1=%b required r0=1 r1=0", resp0_valid, resp1_valid);
        end
        issue(1'b0, 1'b0, 9'h005, 32'h0);
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (resp0_valid !== 1'b1 || resp0_rdata !== 32'hDEADBEEF) begin
            failures++;
            $display("FAIL rd_resp: got v=%b data=%h required v=1 data=deadbeef", resp0_valid, resp0_rdata);
        end
        $display("test_write_read done");
    endtask

    task automatic test_round_robin();
        logic exp_port;
        int   n;
        issue(1'b1, 1'b1, 9'h010, 32'h11);
        issue(1'b1, 1'b1, 9'h020, 32'h22);
        pulse_reset();
        @(posedge clk); #1;
        req0_valid = 1'b1; req0_we = 1'b0; req0_addr = 9'h010;
        req1_valid = 1'b1; req1_we = 1'b0; req1_addr = 9'h020;
        exp_port = 1'b0;
        for (int i = 0; i < 8; i++) begin
            n = 0;
            do begin
                @(negedge clk);
                n++;
            end while (!(req0_ready || req1_ready) && n < 10);
            checks++;
            if (!(req0_ready || req1_ready) || req1_ready !== exp_port) begin
                failures++;
                $display("FAIL rr_grant%0d: got r0=%b r1=%b required port %0d", i, req0_ready, req1_ready, exp_port);
            end
            @(negedge clk);
            @(negedge clk);
            checks++;
            if (exp_port ? (resp1_valid !== 1'b1 || resp1_rdata !== 32'h22)
                         : (resp0_valid !== 1'b1 || resp0_rdata !== 32'h11)) begin
                failures++;
                $display("FAIL rr_resp%0d: got r0=%b/%h r1=%b/%h required port %0d data", i,
                         resp0_valid, resp0_rdata, resp1_valid, resp1_rdata, exp_port);
            end
            $display("rr grant %0d to port %0d", i, exp_port);
            exp_port = !exp_port;
        end
        @(posedge clk); #1;
        req0_valid = 1'b0; req1_valid = 1'b0;
    endtask

    task automatic test_fixed_prio();
        int cnt0, bad1;
        pulse_reset();
        @(posedge clk); #1;
        req0_valid = 1'b1; req0_we = 1'b0; req0_addr = 9'h010;
        req1_valid = 1'b1; req1_we = 1'b0; req1_addr = 9'h020;
        cnt0 = 0; bad1 = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (fp_req0_ready) cnt0++;
            if (fp_req1_ready) bad1++;
        end
        checks++;
        if (cnt0 != 4) begin
            failures++;
            $display("FAIL fp_port0_grants: got %0d required 4", cnt0);
        end
        checks++;
        if (bad1 != 0) begin
            failures++;
            $display("FAIL fp_port1_starved: got %0d port1 readies required 0", bad1);
        end
        @(posedge clk); #1 req0_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (fp_req1_ready !== 1'b1 || fp_req0_ready !== 1'b0) begin
            failures++;
            $display("FAIL fp_port1_after_drop: got r0=%b r1=%b required r0=0 r1=1", fp_req0_ready, fp_req1_ready);
        end
        @(posedge clk); #1 req1_valid = 1'b0;
        $display("test_fixed_prio done grants0=%0d", cnt0);
    endtask

    task automatic test_max_addr();
        issue(1'b1, 1'b1, 9'h1FF, 32'h0000CAFE);
        @(negedge clk);
        checks++;
        if (mem_write !== 1'b1 || a !== 9'h1FF || wd !== 32'h0000CAFE) begin
            failures++;
            $display("FAIL max_wr_access: got wr=%b a=%h wd=%h required 1/1ff/0000cafe", mem_write, a, wd);
        end
        @(negedge clk);
        checks++;
        if (resp1_valid !== 1'b1 || resp1_rdata !== 32'h0) begin
            failures++;
            $display("FAIL max_wr_resp: got v=%b data=%h required v=1 data=0", resp1_valid, resp1_rdata);
        end
        checks++;
        if ({mem_read, mem_write, a, wd} !== '0) begin
            failures++;
            $display("FAIL resp_mem_idle: got rd=%b wr=%b a=%h wd=%h required 0", mem_read, mem_write, a, wd);
        end
        issue(1'b1, 1'b0, 9'h1FF, 32'h0);
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (resp1_valid !== 1'b1 || resp1_rdata !== 32'h0000CAFE) begin
            failures++;
            $display("FAIL max_rd_resp: got v=%b data=%h required v=1 data=0000cafe", resp1_valid, resp1_rdata);
        end
        $display("test_max_addr done");
    endtask

    task automatic test_reset_access();
        int cnt;
        issue(1'b0, 1'b1, 9'h003, 32'h12345678);
        #2;
        checks++;
        if (mem_write !== 1'b1) begin
            failures++;
            $display("FAIL ra_pre: got wr=%b required 1", mem_write);
        end
        reset = 1'b1;
        #1;
        checks++;
        if (mem_write !== 1'b0 || a !== '0) begin
            failures++;
            $display("FAIL ra_drop: got wr=%b a=%h required wr=0 a=0", mem_write, a);
        end
        @(posedge clk); #1 reset = 1'b0;
        cnt = 0;
        repeat (3) begin
            @(negedge clk);
            if (resp0_valid || resp1_valid) cnt++;
        end
        checks++;
        if (cnt != 0) begin
            failures++;
            $display("FAIL ra_no_resp: got %0d pulses required 0", cnt);
        end
        @(posedge clk); #1;
        req0_valid = 1'b1; req0_we = 1'b0; req0_addr = 9'h003;
        req1_valid = 1'b1; req1_we = 1'b0; req1_addr = 9'h020;
        @(negedge clk);
        checks++;
        if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin
            failures++;
            $display("FAIL ra_first_grant: got r0=%b r1=%b required r0=1 r1=0", req0_ready, req1_ready);
        end
        @(posedge clk); #1;
        req0_valid = 1'b0; req1_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (resp0_valid !== 1'b1 || resp0_rdata !== 32'h0) begin
            failures++;
            $display("FAIL ra_readback: got v=%b data=%h required v=1 data=0", resp0_valid, resp0_rdata);
        end
        $display("test_reset_access done");
    endtask

    task automatic test_cancel();
        int cnt;
        issue(1'b0, 1'b0, 9'h010, 32'h0);
        req1_valid = 1'b1; req1_we = 1'b1; req1_addr = 9'h040; req1_wdata = 32'hBAD0BAD0;
        @(negedge clk);
        checks++;
        if (req1_ready !== 1'b0) begin
            failures++;
            $display("FAIL cancel_busy_ready: got r1=%b required 0", req1_ready);
        end
        @(posedge clk); #1 req1_valid = 1'b0;
        cnt = 0;
        repeat (4) begin
            @(negedge clk);
            if (resp1_valid || (mem_write && a == 9'h040)) cnt++;
        end
        checks++;
        if (cnt != 0) begin
            failures++;
            $display("FAIL cancel_activity: got %0d port1 events required 0", cnt);
        end
        $display("test_cancel done");
    endtask

    task automatic test_random();
        logic seen0, seen1;
        int   acc;
        seen0 = 1'b0; seen1 = 1'b0; acc = 0;
        for (int i = 0; i < 300; i++) begin
            @(posedge clk); #1;
            if (req0_valid && (seen0 || $urandom_range(0, 15) == 0)) req0_valid = 1'b0;
            else if (!req0_valid && $urandom_range(0, 2) == 0) begin
                req0_valid = 1'b1; req0_we = 1'($urandom_range(0, 1));
                req0_addr = 9'($urandom_range(0, 15)); req0_wdata = $urandom;
            end
            if (req1_valid && (seen1 || $urandom_range(0, 15) == 0)) req1_valid = 1'b0;
            else if (!req1_valid && $urandom_range(0, 2) == 0) begin
                req1_valid = 1'b1; req1_we = 1'($urandom_range(0, 1));
                req1_addr = ($urandom_range(0, 7) == 0) ? 9'h1FF : 9'($urandom_range(0, 15));
                req1_wdata = $urandom;
            end
            @(negedge clk);
            seen0 = req0_ready; seen1 = req1_ready;
            if (seen0 || seen1) acc++;
        end
        @(posedge clk); #1;
        req0_valid = 1'b0; req1_valid = 1'b0;
        repeat (4) @(negedge clk);
        checks++;
        if (acc < 20) begin
            failures++;
            $display("FAIL random_traffic: got %0d accepts required at least 20", acc);
        end
        $display("test_random done accepts=%0d", acc);
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_round_robin();
        test_fixed_prio();
        test_max_addr();
        test_reset_access();
        test_cancel();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

endmodule
